// File: rtl/qspi_pkg.sv
// qspi_pkg
//   Shared types and constants for the QSPI request arbiter.
//   - arb_state_t         : arbiter FSM states
//   - OWN_NONE/XIP/IND    : owner_out encodings
//   - XIP_CMD_PLACEHOLDER : opcode latched for XIP grants; the sequencer
//                           substitutes its own XIP read opcode
package qspi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        RUN,
        DONE
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_XIP  = 2'b01;
    localparam logic [1:0] OWN_IND  = 2'b10;

    localparam logic [7:0] XIP_CMD_PLACEHOLDER = 8'h00;

endpackage

// File: rtl/qspi_arb_watchdog.sv
// qspi_arb_watchdog
//   Clearable cycle counter with a limit compare. Counts cycles with inc
//   high; expired is asserted combinationally during the cycle that would
//   bring the count to LIMIT, so the owner can leave on exactly the
//   LIMIT-th counted cycle.
// Ports:
//   sclk, rst_n : clock, asynchronous active-low reset
//   clr         : synchronous clear (priority over inc)
//   inc         : count this cycle
//   expired     : this counted cycle is the LIMIT-th one
module qspi_arb_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    assign expired = inc && (count == CNT_W'(LIMIT - 1));

    // NOTE: sequential state is always updated with <= so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != CNT_W'(LIMIT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/qspi_req_arbiter.sv
// qspi_req_arbiter
//   Shares one QSPI sequencer between the AHB XIP read path and the
//   indirect register-command path. Arbitrates in IDLE, latches the
//   winner's descriptor, pulses seq_start_out, supervises seq_busy_in with
//   a start watchdog and returns done/err to the owner. Moore machine: all
//   outputs are flops or decodes of state plus latched owner/error.
// Ports:
//   sclk, rst_n                      : clock, asynchronous active-low reset
//   xip_req_in/xip_addr_in           : XIP request (level) and address
//   xip_ack_out/xip_done_out         : XIP descriptor-latched / finished pulses
//   ind_req_in/ind_addr_in/ind_cmd_in: indirect request, address, opcode
//   ind_ack_out/ind_done_out         : indirect descriptor-latched / finished
//   err_out                          : with done, start watchdog expired
//   seq_start_out                    : one-cycle start to the sequencer
//   seq_addr_out/seq_cmd_out/
//   seq_is_xip_out                   : latched descriptor
//   seq_busy_in                      : sequencer busy
//   owner_out                        : current owner (OWN_* codes)
module qspi_req_arbiter
    import qspi_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int START_TIMEOUT  = 16,
    parameter int XIP_STREAK_MAX = 4
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              xip_req_in,
    input  logic [ADDR_W-1:0] xip_addr_in,
    output logic              xip_ack_out,
    output logic              xip_done_out,
    input  logic              ind_req_in,
    input  logic [ADDR_W-1:0] ind_addr_in,
    input  logic [7:0]        ind_cmd_in,
    output logic              ind_ack_out,
    output logic              ind_done_out,
    output logic              err_out,
    output logic              seq_start_out,
    output logic [ADDR_W-1:0] seq_addr_out,
    output logic [7:0]        seq_cmd_out,
    output logic              seq_is_xip_out,
    input  logic              seq_busy_in,
    output logic [1:0]        owner_out
);

    localparam int STREAK_W = $clog2(XIP_STREAK_MAX + 1);

    arb_state_t          state, state_nxt;
    logic [STREAK_W-1:0] streak;
    logic                streak_full;
    logic                err_flag;
    logic                grant_xip, grant_ind;
    logic                wd_expired;

    qspi_arb_watchdog #(
        .LIMIT (START_TIMEOUT)
    ) u_watchdog (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .clr     (state == LAUNCH),
        .inc     (state == WAIT_BUSY && !seq_busy_in),
        .expired (wd_expired)
    );

    assign streak_full = (streak == STREAK_W'(XIP_STREAK_MAX));

    // Arbitration. A stale busy from the sequencer blocks any grant. XIP
    // wins ties until it has starved a waiting indirect request for
    // XIP_STREAK_MAX consecutive grants.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant_xip = 1'b0;
        grant_ind = 1'b0;
        if (state == IDLE && !seq_busy_in) begin
            if (xip_req_in && !(ind_req_in && streak_full)) begin
                grant_xip = 1'b1;
            end else if (ind_req_in) begin
                grant_ind = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (grant_xip || grant_ind) state_nxt = LAUNCH;
            LAUNCH:    state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (seq_busy_in)     state_nxt = RUN;
                else if (wd_expired) state_nxt = DONE;
            end
            RUN:       if (!seq_busy_in) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            seq_addr_out   <= '0;
            seq_cmd_out    <= '0;
            seq_is_xip_out <= 1'b0;
            owner_out      <= OWN_NONE;
            streak         <= '0;
            err_flag       <= 1'b0;
        end else begin
            state <= state_nxt;

            // Descriptor is captured only on grant, so it holds from LAUNCH
            // through DONE whatever the requesters do meanwhile.
            if (grant_xip) begin
                seq_addr_out   <= xip_addr_in;
                seq_cmd_out    <= XIP_CMD_PLACEHOLDER;
                seq_is_xip_out <= 1'b1;
                owner_out      <= OWN_XIP;
            end else if (grant_ind) begin
                seq_addr_out   <= ind_addr_in;
                seq_cmd_out    <= ind_cmd_in;
                seq_is_xip_out <= 1'b0;
                owner_out      <= OWN_IND;
            end else if (state == DONE) begin
                owner_out <= OWN_NONE;
            end

            // Streak only measures starvation of a waiting indirect request.
            if (grant_ind || (state == IDLE && !ind_req_in)) begin
                streak <= '0;
            end else if (grant_xip && !streak_full) begin
                streak <= streak + 1'b1;
            end

            if (state == LAUNCH) begin
                err_flag <= 1'b0;
            end else if (state == WAIT_BUSY && !seq_busy_in && wd_expired) begin
                err_flag <= 1'b1;
            end
        end
    end

    assign seq_start_out = (state == LAUNCH);
    assign xip_ack_out   = (state == LAUNCH) && (owner_out == OWN_XIP);
    assign ind_ack_out   = (state == LAUNCH) && (owner_out == OWN_IND);
    assign xip_done_out  = (state == DONE) && (owner_out == OWN_XIP);
    assign ind_done_out  = (state == DONE) && (owner_out == OWN_IND);
    assign err_out       = (state == DONE) && err_flag;

endmodule

// File: tb/tb_qspi_req_arbiter.sv
// tb_qspi_req_arbiter
//   Directed bench for qspi_req_arbiter. Expected descriptors are queued
//   when a request is raised and checked when the arbiter starts/finishes
//   the transfer. A small behavioural sequencer answers seq_start_out.
module tb_qspi_req_arbiter;

    localparam int ADDR_W         = 32;
    localparam int START_TIMEOUT  = 16;
    localparam int XIP_STREAK_MAX = 4;

    typedef struct {
        logic        is_xip;
        logic [31:0] addr;
        logic [7:0]  cmd;
        logic        err;
    } exp_t;

    logic              sclk;
    logic              rst_n;
    logic              xip_req_in;
    logic [ADDR_W-1:0] xip_addr_in;
    logic              xip_ack_out;
    logic              xip_done_out;
    logic              ind_req_in;
    logic [ADDR_W-1:0] ind_addr_in;
    logic [7:0]        ind_cmd_in;
    logic              ind_ack_out;
    logic              ind_done_out;
    logic              err_out;
    logic              seq_start_out;
    logic [ADDR_W-1:0] seq_addr_out;
    logic [7:0]        seq_cmd_out;
    logic              seq_is_xip_out;
    logic              seq_busy_in;
    logic [1:0]        owner_out;

    exp_t sb[$];
    exp_t cur;
    int   n_cmp      = 0;
    int   n_err      = 0;
    int   done_count = 0;

    // Sequencer model controls
    int   busy_delay = 3;
    int   busy_len   = 20;
    logic seq_hang   = 1'b0;
    logic stale_busy = 1'b0;

    qspi_req_arbiter #(
        .ADDR_W         (ADDR_W),
        .START_TIMEOUT  (START_TIMEOUT),
        .XIP_STREAK_MAX (XIP_STREAK_MAX)
    ) dut (
        .sclk           (sclk),
        .rst_n          (rst_n),
        .xip_req_in     (xip_req_in),
        .xip_addr_in    (xip_addr_in),
        .xip_ack_out    (xip_ack_out),
        .xip_done_out   (xip_done_out),
        .ind_req_in     (ind_req_in),
        .ind_addr_in    (ind_addr_in),
        .ind_cmd_in     (ind_cmd_in),
        .ind_ack_out    (ind_ack_out),
        .ind_done_out   (ind_done_out),
        .err_out        (err_out),
        .seq_start_out  (seq_start_out),
        .seq_addr_out   (seq_addr_out),
        .seq_cmd_out    (seq_cmd_out),
        .seq_is_xip_out (seq_is_xip_out),
        .seq_busy_in    (seq_busy_in),
        .owner_out      (owner_out)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic is_xip, input logic [31:0] addr,
                                input logic [7:0] cmd, input logic err);
        exp_t e;
        e.is_xip = is_xip;
        e.addr   = addr;
        e.cmd    = cmd;
        e.err    = err;
        return e;
    endfunction

    // One cycle step: requesters drop their level request once acked.
    task automatic tick();
        @(negedge sclk);
        if (xip_ack_out === 1'b1) xip_req_in = 1'b0;
        if (ind_ack_out === 1'b1) ind_req_in = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!(xip_done_out === 1'b1 || ind_done_out === 1'b1) && cycles < bound);
        if (!(xip_done_out === 1'b1 || ind_done_out === 1'b1))
            check({tag, "_done_timeout"}, 0, 1);
    endtask

    // Behavioural sequencer: busy rises busy_delay cycles after start and
    // lasts busy_len cycles; seq_hang ignores start; stale_busy drives busy
    // while no transfer is in progress.
    initial begin
        seq_busy_in = 1'b0;
        forever begin
            @(negedge sclk);
            if (seq_start_out === 1'b1 && !seq_hang) begin
                repeat (busy_delay) @(negedge sclk);
                seq_busy_in = 1'b1;
                repeat (busy_len) @(negedge sclk);
                seq_busy_in = 1'b0;
            end else begin
                seq_busy_in = stale_busy;
            end
        end
    end

    // Scoreboard: pop at start, check routing/error at done.
    initial begin
        forever begin
            @(negedge sclk);
            if (rst_n === 1'b1) begin
                if ((xip_ack_out | ind_ack_out) === 1'b1)
                    check("ack_without_start", seq_start_out, 1);
                if (seq_start_out === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_start", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        check("start_is_xip", seq_is_xip_out, cur.is_xip);
                        check("start_addr", seq_addr_out, cur.addr);
                        check("start_cmd", seq_cmd_out, cur.cmd);
                        check("start_owner", owner_out, cur.is_xip ? 2'b01 : 2'b10);
                        check("start_xip_ack", xip_ack_out, cur.is_xip);
                        check("start_ind_ack", ind_ack_out, !cur.is_xip);
                    end
                end
                if ((xip_done_out | ind_done_out) === 1'b1) begin
                    done_count++;
                    check("done_xip", xip_done_out, cur.is_xip);
                    check("done_ind", ind_done_out, !cur.is_xip);
                    check("done_err", err_out, cur.err);
                    check("done_addr_hold", seq_addr_out, cur.addr);
                    check("done_cmd_hold", seq_cmd_out, cur.cmd);
                    check("done_owner", owner_out, cur.is_xip ? 2'b01 : 2'b10);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int xfer;
        int stuck;
        int done_before;
        logic exp_x;

        rst_n       = 1'b0;
        xip_req_in  = 1'b0;
        xip_addr_in = '0;
        ind_req_in  = 1'b0;
        ind_addr_in = '0;
        ind_cmd_in  = '0;
        xfer        = busy_delay + busy_len + 1;

        // Reset state
        repeat (2) tick();
        check("reset_outputs",
              {owner_out, seq_is_xip_out, seq_addr_out, seq_cmd_out, seq_start_out,
               xip_ack_out, ind_ack_out, xip_done_out, ind_done_out, err_out}, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single XIP transfer
        sb.push_back(mk(1'b1, 32'h0000_1000, 8'h00, 1'b0));
        xip_addr_in = 32'h0000_1000;
        xip_req_in  = 1'b1;
        tick();
        check("t1_start_latency", seq_start_out, 1);
        check("t1_xip_ack", xip_ack_out, 1);
        repeat (10) tick();
        xip_addr_in = 32'hDEAD_BEEF;
        wait_done("t1", 100, n);
        check("t1_done_delay", 10 + n, xfer);
        tick();
        check("t1_owner_released", owner_out, 2'b00);

        // Indirect transfer
        sb.push_back(mk(1'b0, 32'h00AB_CDEF, 8'h06, 1'b0));
        ind_addr_in = 32'h00AB_CDEF;
        ind_cmd_in  = 8'h06;
        ind_req_in  = 1'b1;
        tick();
        check("t2_start_latency", seq_start_out, 1);
        check("t2_no_xip_ack", xip_ack_out, 0);
        ind_cmd_in = 8'hFF;
        wait_done("t2", 100, n);
        check("t2_done_delay", n, xfer);
        tick();

        // Start watchdog: sequencer never goes busy
        seq_hang = 1'b1;
        sb.push_back(mk(1'b1, 32'h0000_2000, 8'h00, 1'b1));
        xip_addr_in = 32'h0000_2000;
        xip_req_in  = 1'b1;
        tick();
        check("t3_start_latency", seq_start_out, 1);
        wait_done("t3", 100, n);
        check("t3_timeout_delay", n, START_TIMEOUT + 1);
        check("t3_err_with_done", {err_out, xip_done_out}, 2'b11);
        tick();
        check("t3_err_one_cycle", err_out, 0);
        seq_hang = 1'b0;

        // Stale busy blocks the grant
        @(posedge sclk);
        #1 stale_busy = 1'b1;
        tick();
        sb.push_back(mk(1'b1, 32'h0000_3000, 8'h00, 1'b0));
        xip_addr_in = 32'h0000_3000;
        xip_req_in  = 1'b1;
        stuck = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (xip_ack_out === 1'b1) stuck++;
        end
        check("t4_no_ack_while_busy", stuck, 0);
        @(posedge sclk);
        #1 stale_busy = 1'b0;
        tick();
        check("t4_no_ack_before_idle_sample", xip_ack_out, 0);
        tick();
        check("t4_ack_after_busy_low", xip_ack_out, 1);
        wait_done("t4", 100, n);
        check("t4_done_delay", n, xfer);
        tick();

        // Starvation bound: X,X,X,X,I then streak restarts at 0
        busy_delay  = 1;
        busy_len    = 2;
        xip_addr_in = 32'h0000_4000;
        ind_addr_in = 32'h0000_5000;
        ind_cmd_in  = 8'h0B;
        for (int g = 0; g < 11; g++) begin
            exp_x = (g != 4 && g != 9);
            sb.push_back(mk(exp_x, exp_x ? 32'h0000_4000 : 32'h0000_5000,
                            exp_x ? 8'h00 : 8'h0B, 1'b0));
        end
        xip_req_in = 1'b1;
        ind_req_in = 1'b1;
        for (int g = 0; g < 11; g++) begin
            wait_done("t5", 200, n);
            if (g != 4 && g != 9 && g != 10) xip_req_in = 1'b1;
            if (g == 4) ind_req_in = 1'b1;
        end
        repeat (3) tick();
        check("t5_no_pending_grants", sb.size(), 0);

        // Reset in RUN drops the transfer
        busy_delay  = 3;
        busy_len    = 20;
        sb.push_back(mk(1'b1, 32'h0000_6000, 8'h00, 1'b0));
        xip_addr_in = 32'h0000_6000;
        xip_req_in  = 1'b1;
        tick();
        check("t6_start_latency", seq_start_out, 1);
        repeat (8) tick();
        done_before = done_count;
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_reset_outputs",
              {owner_out, seq_is_xip_out, seq_addr_out, seq_cmd_out, seq_start_out,
               xip_ack_out, ind_ack_out, xip_done_out, ind_done_out, err_out}, 0);
        repeat (2) tick();
        #2 rst_n = 1'b1;
        stuck = 0;
        while (seq_busy_in === 1'b1 && stuck < 40) begin
            tick();
            stuck++;
        end
        repeat (3) tick();
        check("t6_no_done_after_reset", done_count, done_before);
        sb.push_back(mk(1'b0, 32'h5555_0000, 8'h9F, 1'b0));
        ind_addr_in = 32'h5555_0000;
        ind_cmd_in  = 8'h9F;
        ind_req_in  = 1'b1;
        tick();
        check("t6_restart_latency", seq_start_out, 1);
        wait_done("t6", 100, n);
        check("t6_done_delay", n, xfer);
        repeat (3) tick();

        check("sb_drained", sb.size(), 0);
        check("done_total", done_count, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qspi_req_arbiter.md
Name: qspi_req_arbiter

Overview:
Shares the single QSPI sequencer (the start/busy FSM that drives cs_n, sclk gating and the shift registers) between two requesters: the AHB XIP read path and the indirect register-command path. It arbitrates, latches the winner's descriptor, pulses the sequencer start, supervises busy with a watchdog, and returns done/error to the owner. It sits between the AHB slave controller/register block and the QSPI sequencer, in the sclk domain.

Parameters:
ADDR_W, 32, address width of request descriptors
START_TIMEOUT, 16, sclk cycles allowed between start pulse and sequencer busy rising
XIP_STREAK_MAX, 4, consecutive XIP grants allowed while an indirect request waits

Ports:
sclk  in  1  clock
rst_n  in  1  asynchronous active-low reset
xip_req_in  in  1  XIP read request, level, held until xip_ack_out
xip_addr_in  in  ADDR_W  XIP read address
xip_ack_out  out  1  one-cycle pulse: descriptor latched
xip_done_out  out  1  one-cycle pulse: XIP transfer finished
ind_req_in  in  1  indirect command request, level, held until ind_ack_out
ind_addr_in  in  ADDR_W  indirect address
ind_cmd_in  in  8  indirect opcode
ind_ack_out  out  1  one-cycle pulse: descriptor latched
ind_done_out  out  1  one-cycle pulse: indirect transfer finished
err_out  out  1  one-cycle pulse with done: watchdog expired
seq_start_out  out  1  one-cycle start pulse to sequencer
seq_addr_out  out  ADDR_W  latched address, stable from start until DONE
seq_cmd_out  out  8  latched opcode (8'h00 for XIP; sequencer selects its own XIP opcode)
seq_is_xip_out  out  1  latched owner: 1 = XIP, 0 = indirect
seq_busy_in  in  1  sequencer busy
owner_out  out  2  2'b00 none, 2'b01 XIP, 2'b10 indirect

Behaviour:
- Reset (async, any state): state IDLE; all pulses 0; seq_addr_out 0, seq_cmd_out 0, seq_is_xip_out 0, owner_out 2'b00; streak counter 0; watchdog 0. Mid-transfer reset drops the transfer; no done is issued.
- Moore FSM, all outputs registered/state-decoded. States: IDLE, LAUNCH, WAIT_BUSY, RUN, DONE.
- IDLE: arbitrates only when seq_busy_in = 0 (stale busy blocks grant). Winner selection:
  - only one requester -> it wins;
  - both -> XIP wins unless streak = XIP_STREAK_MAX, then indirect wins.
  - On grant latch descriptor, set owner_out, go LAUNCH.
- Streak counter: +1 on XIP grant while ind_req_in = 1 (saturate at XIP_STREAK_MAX); cleared on indirect grant or whenever ind_req_in = 0 in IDLE.
- LAUNCH (exactly 1 cycle): ack to owner and seq_start_out = 1 in same cycle -> WAIT_BUSY, watchdog cleared.
- Latency: request sampled at edge k in IDLE -> ack/start high during cycle k+1.
- WAIT_BUSY: seq_busy_in = 1 -> RUN. Else watchdog +1; reaching START_TIMEOUT -> DONE with error flag set.
- RUN: remain while seq_busy_in = 1; busy 0 -> DONE. No timeout in RUN (transfer length is sequencer-defined).
- DONE (1 cycle): done pulse to owner; err_out = error flag; owner_out -> 2'b00 on exit; -> IDLE. Earliest next grant one cycle after DONE.
- Requests are not sampled outside IDLE; a requester deasserting before ack is a protocol violation (assertion in bench, no RTL recovery).
- Both req asserted together with streak saturated -> exactly one ack (indirect); XIP waits, no loss.
- Descriptor outputs hold from LAUNCH through DONE regardless of input changes.

Decomposition:
- Package qspi_pkg: arb_state_t enum (IDLE, LAUNCH, WAIT_BUSY, RUN, DONE); owner codes OWN_NONE/OWN_XIP/OWN_IND; XIP_CMD_PLACEHOLDER = 8'h00.
- One natural sub-module: qspi_arb_watchdog (clearable counter with limit compare, produces expired).

Test Plan:
- Single XIP: xip_req_in=1, addr 32'h0000_1000; sequencer busy 3 cycles after start for 20 cycles -> ack+start at k+1, seq_addr_out=32'h1000, seq_is_xip_out=1, xip_done_out pulse 1 cycle after busy falls, err_out=0.
- Indirect: ind_cmd_in=8'h06, addr 32'h00AB_CDEF -> seq_cmd_out=8'h06, owner_out=2'b10, ind_done_out only, xip_done_out never pulses.
- Starvation: both requests held continuously, XIP re-asserted after each done -> grants X,X,X,X,I (XIP_STREAK_MAX=4), streak returns to 0 after I.
- Watchdog: seq_busy_in held 0 after start -> DONE after exactly 16 WAIT_BUSY cycles, done+err_out pulse together to owner.
- Stale busy: seq_busy_in=1 in IDLE with xip_req_in=1 -> no ack until busy falls; ack on cycle after busy=0 sampled.
- Reset mid-RUN: rst_n low during RUN -> all outputs 0 asynchronously, no done pulse; after release new request serviced normally.
